mutex_lock_client: RTL and testbench
====================================

Name: mutex_lock_client

Overview:
- Avalon-MM master front-end sitting directly upstream of the hardware mutex slave (32-bit data, 1-bit address: 0 = {owner[31:16], value[15:0]}, 1 = reset flag).
- Converts single-cycle acquire/release requests from a local agent (CPU shim or accelerator) into the mutex protocol: write-try, read-back check, retry with backoff, release.
- Exposes a simple granted/fail/done status to the agent.

Parameters:
- OWNER_ID, 16'h0001, owner tag written to bits [31:16].
- LOCK_VALUE, 16'h0001, value written on acquire; must be nonzero.
- MAX_RETRIES, 8'd0, failed checks before giving up; 0 = retry forever.
- BACKOFF_CYCLES, 8'd4, idle cycles between attempts; minimum 1.
- BACKOFF_MAX, 16'd256, backoff saturation value (used only with the optional feature).

Ports:
- clk  in  1  clock
- reset_n  in  1  async active-low reset
- req_acquire  in  1  one-cycle acquire request
- req_release  in  1  one-cycle release request
- granted  out  1  lock held by this client
- busy  out  1  acquire or release sequence in progress
- fail  out  1  one-cycle pulse: retries exhausted
- done  out  1  one-cycle pulse: release write issued
- m_address  out  1  mutex register select
- m_chipselect  out  1  slave select
- m_write  out  1  write strobe
- m_read  out  1  read strobe
- m_writedata  out  32  write data
- m_readdata  in  32  read data, zero-latency (valid in the same cycle as m_read; no waitrequest)

Behaviour:
- Reset values: all outputs 0, state IDLE, retry_cnt 0, backoff counter 0.
- Reset is asynchronous, active-low on reset_n; clock is clk.
- FSM states: IDLE, WRITE_TRY, READ_CHECK, BACKOFF, HELD, RELEASE. All master outputs are registered-state decodes and are 0 outside the states listed below.
- IDLE:
  - req_acquire=1 -> WRITE_TRY; clear retry_cnt; load backoff with BACKOFF_CYCLES.
  - req_release is ignored.
  - If both requests are high, acquire wins.
- WRITE_TRY (1 cycle):
  - m_chipselect=1, m_write=1, m_address=0, m_writedata={OWNER_ID, LOCK_VALUE}.
  - -> READ_CHECK.
- READ_CHECK (1 cycle):
  - m_chipselect=1, m_read=1, m_address=0; sample m_readdata.
  - m_readdata == {OWNER_ID, LOCK_VALUE} -> HELD.
  - Mismatch: retry_cnt+1 (saturating 8-bit). If MAX_RETRIES != 0 and the new count == MAX_RETRIES -> IDLE with fail=1 for one cycle. Otherwise -> BACKOFF with the counter loaded.
- BACKOFF: counter decrements each cycle; at 1 -> WRITE_TRY. Gives exactly BACKOFF_CYCLES idle bus cycles.
- HELD:
  - granted=1 (decoded: state==HELD).
  - req_release -> RELEASE; req_acquire is ignored.
- RELEASE (1 cycle):
  - m_chipselect=1, m_write=1, m_address=0, m_writedata={OWNER_ID, 16'h0000}.
  - done=1 in the same cycle; granted=0.
  - -> IDLE.
- busy = state in {WRITE_TRY, READ_CHECK, BACKOFF, RELEASE}.
- Latency, uncontended: req_acquire sampled at edge E0 -> WRITE_TRY E0..E1 -> READ_CHECK E1..E2 -> granted high from E2.
- Requests arriving while busy are dropped; they are not queued.
- Reset mid-sequence: returns to IDLE immediately. No automatic release is issued; the slave holds its own state.
- m_address=1 (reset-flag register) is never driven by this block.

Optional Feature:
- Macro: MUTEX_CLIENT_EXP_BACKOFF_EN.
- Defined:
  - Backoff reload doubles after each failed READ_CHECK, saturating at BACKOFF_MAX; 16-bit counter.
  - Reload resets to BACKOFF_CYCLES on each new req_acquire.
- Undefined: every backoff is exactly BACKOFF_CYCLES; 8-bit counter; BACKOFF_MAX unused.

Decomposition:
- Shared package mutex_pkg holds:
  - state enum for the six states
  - register address constants MUTEX_ADDR_STATE=1'b0 and MUTEX_ADDR_RESET=1'b1
  - field slices OWNER_MSB/LSB=31/16 and VALUE_MSB/LSB=15/0
- Sub-module mutex_backoff_ctr: load/decrement counter plus the optional doubling reload. All other logic stays in a single FSM module.

Test Plan (bench with a behavioural mutex slave; OWNER_ID=0x0001, LOCK_VALUE=0x0001, BACKOFF_CYCLES=4):
- Free mutex, pulse req_acquire -> one write of 0x00010001, then one read, granted=1 two cycles after the request; slave holds 0x00010001.
- Slave pre-held at 0x00020005, MAX_RETRIES=3 -> three write/read pairs, each separated by 4 idle cycles, then fail=1 for one cycle, granted=0, slave unchanged.
- Slave pre-held by 0x0002, released after 10 cycles -> client retries and then obtains granted=1; slave reads 0x00010001.
- In HELD, pulse req_release -> single write of 0x00010000, done=1 in the same cycle, granted=0, slave value 0.
- Assert reset_n low during BACKOFF -> all outputs 0 asynchronously; IDLE after release; a following req_acquire proceeds normally.
- With MUTEX_CLIENT_EXP_BACKOFF_EN, contended slave -> idle gaps of 4, 8, 16, 32 … saturating at 256.

Source files
------------

// File: rtl/mutex_pkg.sv
// ---------------------------------------------------------------------------
// | mutex_pkg                                                               |
// | Shared FSM states, register map and field slices for the mutex client.  |
// | Revision: 1.0                                                           |
// ---------------------------------------------------------------------------
`default_nettype none

package mutex_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WRITE_TRY  = 3'd1,
    S_READ_CHECK = 3'd2,
    S_BACKOFF    = 3'd3,
    S_HELD       = 3'd4,
    S_RELEASE    = 3'd5
  } mutex_state_t;

  localparam logic MUTEX_ADDR_STATE = 1'b0;
  localparam logic MUTEX_ADDR_RESET = 1'b1;

  localparam int OWNER_MSB = 31;
  localparam int OWNER_LSB = 16;
  localparam int VALUE_MSB = 15;
  localparam int VALUE_LSB = 0;

endpackage

`default_nettype wire

// File: rtl/mutex_backoff_ctr.sv
// ---------------------------------------------------------------------------
// | mutex_backoff_ctr                                                       |
// | Backoff down-counter; MUTEX_CLIENT_EXP_BACKOFF_EN enables doubling.     |
// | Revision: 1.0                                                           |
// ---------------------------------------------------------------------------
`default_nettype none

module mutex_backoff_ctr #(
  parameter logic [7:0]  BACKOFF_CYCLES = 8'd4
`ifdef MUTEX_CLIENT_EXP_BACKOFF_EN
  ,
  parameter logic [15:0] BACKOFF_MAX    = 16'd256
`endif
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic load,
  input  logic dec,
  output logic expire
);

`ifdef MUTEX_CLIENT_EXP_BACKOFF_EN
  logic [15:0] r_count;
  logic [15:0] r_reload;
  logic [16:0] w_doubled;

  assign w_doubled = {r_reload, 1'b0};

  // The counter takes the current reload; the reload then doubles toward the cap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count  <= 16'd0;
      r_reload <= 16'd0;
    end else if (start) begin
      r_count  <= {8'd0, BACKOFF_CYCLES};
      r_reload <= {8'd0, BACKOFF_CYCLES};
    end else if (load) begin
      r_count  <= r_reload;
      r_reload <= (w_doubled > {1'b0, BACKOFF_MAX}) ? BACKOFF_MAX : w_doubled[15:0];
    end else if (dec && (r_count != 16'd0)) begin
      r_count <= r_count - 16'd1;
    end
  end

  assign expire = (r_count == 16'd1);
`else
  logic [7:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= 8'd0;
    end else if (start || load) begin
      r_count <= BACKOFF_CYCLES;
    end else if (dec && (r_count != 8'd0)) begin
      r_count <= r_count - 8'd1;
    end
  end

  assign expire = (r_count == 8'd1);
`endif

endmodule

`default_nettype wire

// File: rtl/mutex_lock_client.sv
// ---------------------------------------------------------------------------
// | mutex_lock_client                                                       |
// | Avalon-MM master turning acquire/release pulses into mutex accesses.    |
// | Optional: MUTEX_CLIENT_EXP_BACKOFF_EN (exponential backoff).            |
// | Revision: 1.0                                                           |
// ---------------------------------------------------------------------------
`default_nettype none

module mutex_lock_client
  import mutex_pkg::*;
#(
  parameter logic [15:0] OWNER_ID       = 16'h0001,
  parameter logic [15:0] LOCK_VALUE     = 16'h0001,
  parameter logic [7:0]  MAX_RETRIES    = 8'd0,
  parameter logic [7:0]  BACKOFF_CYCLES = 8'd4,
  parameter logic [15:0] BACKOFF_MAX    = 16'd256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_acquire,
  input  logic        req_release,
  output logic        granted,
  output logic        busy,
  output logic        fail,
  output logic        done,
  output logic        m_address,
  output logic        m_chipselect,
  output logic        m_write,
  output logic        m_read,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata
);

  mutex_state_t r_state;
  logic [7:0]   r_retry_cnt;
  logic         r_fail;

  logic [7:0]   w_retry_next;
  logic         w_match;
  logic         w_give_up;
  logic         w_bo_start;
  logic         w_bo_load;
  logic         w_bo_expire;

  assign w_match      = (m_readdata[OWNER_MSB:OWNER_LSB] == OWNER_ID) &&
                        (m_readdata[VALUE_MSB:VALUE_LSB] == LOCK_VALUE);
  assign w_retry_next = (r_retry_cnt == 8'hFF) ? 8'hFF : r_retry_cnt + 8'd1;
  assign w_give_up    = (MAX_RETRIES != 8'd0) && (w_retry_next == MAX_RETRIES);

  assign w_bo_start = (r_state == S_IDLE) && req_acquire;
  assign w_bo_load  = (r_state == S_READ_CHECK) && !w_match && !w_give_up;

  mutex_backoff_ctr #(
    .BACKOFF_CYCLES (BACKOFF_CYCLES)
`ifdef MUTEX_CLIENT_EXP_BACKOFF_EN
    ,
    .BACKOFF_MAX    (BACKOFF_MAX)
`endif
  ) u_backoff (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (w_bo_start),
    .load    (w_bo_load),
    .dec     (r_state == S_BACKOFF),
    .expire  (w_bo_expire)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_retry_cnt <= 8'd0;
      r_fail      <= 1'b0;
    end else begin
      r_fail <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_acquire) begin
            r_state     <= S_WRITE_TRY;
            r_retry_cnt <= 8'd0;
          end
        end
        S_WRITE_TRY: r_state <= S_READ_CHECK;
        S_READ_CHECK: begin
          if (w_match) begin
            r_state <= S_HELD;
          end else begin
            r_retry_cnt <= w_retry_next;
            if (w_give_up) begin
              r_state <= S_IDLE;
              r_fail  <= 1'b1;
            end else begin
              r_state <= S_BACKOFF;
            end
          end
        end
        S_BACKOFF: begin
          if (w_bo_expire) r_state <= S_WRITE_TRY;
        end
        S_HELD: begin
          if (req_release) r_state <= S_RELEASE;
        end
        S_RELEASE: r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  // Bus strobes are pure decodes of the registered state, so reset clears them at once.
  assign granted      = (r_state == S_HELD);
  assign done         = (r_state == S_RELEASE);
  assign fail         = r_fail;
  assign busy         = (r_state == S_WRITE_TRY) || (r_state == S_READ_CHECK) ||
                        (r_state == S_BACKOFF)   || (r_state == S_RELEASE);
  assign m_address    = MUTEX_ADDR_STATE;
  assign m_write      = (r_state == S_WRITE_TRY) || (r_state == S_RELEASE);
  assign m_read       = (r_state == S_READ_CHECK);
  assign m_chipselect = m_write || m_read;
  assign m_writedata  = (r_state == S_WRITE_TRY) ? {OWNER_ID, LOCK_VALUE} :
                        (r_state == S_RELEASE)   ? {OWNER_ID, 16'h0000}   : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_mutex_lock_client.sv
// ---------------------------------------------------------------------------
// | tb_mutex_lock_client                                                    |
// | Directed bench with a behavioural mutex slave.                          |
// | Revision: 1.0                                                           |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mutex_lock_client;

`ifdef MUTEX_CLIENT_EXP_BACKOFF_EN
  localparam logic [7:0] C_MAX_RETRIES = 8'd9;
`else
  localparam logic [7:0] C_MAX_RETRIES = 8'd3;
`endif
  localparam logic [31:0] C_LOCK_WORD = 32'h0001_0001;
  localparam logic [31:0] C_REL_WORD  = 32'h0001_0000;
  localparam logic [31:0] C_OTHER     = 32'h0002_0005;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_acquire, req_release;
  logic        granted, busy, fail, done;
  logic        m_address, m_chipselect, m_write, m_read;
  logic [31:0] m_writedata, m_readdata;

  logic [31:0] slave_val;
  logic        ext_load;
  logic [31:0] ext_val;

  int n_cmp = 0;
  int n_err = 0;
  int gaps[$];

  always #5 clk = ~clk;

  mutex_lock_client #(
    .OWNER_ID       (16'h0001),
    .LOCK_VALUE     (16'h0001),
    .MAX_RETRIES    (C_MAX_RETRIES),
    .BACKOFF_CYCLES (8'd4),
    .BACKOFF_MAX    (16'd256)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_acquire  (req_acquire),
    .req_release  (req_release),
    .granted      (granted),
    .busy         (busy),
    .fail         (fail),
    .done         (done),
    .m_address    (m_address),
    .m_chipselect (m_chipselect),
    .m_write      (m_write),
    .m_read       (m_read),
    .m_writedata  (m_writedata),
    .m_readdata   (m_readdata)
  );

  // Mutex slave: a write lands only if the mutex is free or already owned by the writer.
  always @(posedge clk) begin
    if (ext_load)
      slave_val <= ext_val;
    else if (m_chipselect && m_write && (m_address == 1'b0) &&
             ((slave_val[15:0] == 16'h0) || (slave_val[31:16] == m_writedata[31:16])))
      slave_val <= m_writedata;
  end
  assign m_readdata = (m_chipselect && m_read) ? slave_val : 32'h0;

  function automatic logic [39:0] outs();
    return {granted, busy, fail, done, m_address, m_chipselect, m_write, m_read, m_writedata};
  endfunction

  function automatic logic [39:0] mk(input bit g, input bit b, input bit f, input bit d,
                                     input bit cs, input bit wr, input bit rd,
                                     input logic [31:0] wd);
    return {g, b, f, d, 1'b0, cs, wr, rd, wd};
  endfunction

  function automatic int exp_gap(input int k);
`ifdef MUTEX_CLIENT_EXP_BACKOFF_EN
    int g;
    g = (k < 8) ? (4 << k) : 256;
    return (g > 256) ? 256 : g;
`else
    return (k >= 0) ? 4 : 0;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slave(input logic [31:0] v);
    ext_val  = v;
    ext_load = 1'b1;
    step();
    ext_load = 1'b0;
  endtask

  // Caller raises req_acquire just before; it is dropped after the first edge.
  task automatic watch(input int budget, input int clr_at,
                       output int writes, output int reads, output int fails,
                       output int bad_wd, output bit grant_seen, output bit expired);
    int idle_run;
    writes = 0; reads = 0; fails = 0; bad_wd = 0; grant_seen = 0; expired = 1;
    idle_run = 0;
    gaps.delete();
    for (int i = 0; i < budget; i++) begin
      step();
      req_acquire = 1'b0;
      if (m_chipselect && m_write) begin
        writes++;
        if (m_writedata !== C_LOCK_WORD) bad_wd++;
        if (reads > 0) gaps.push_back(idle_run);
      end else if (m_chipselect && m_read) begin
        reads++;
        idle_run = 0;
      end else if (reads > 0) begin
        idle_run++;
      end
      ext_load = (i == clr_at);
      if (fail) fails++;
      if (granted) grant_seen = 1'b1;
      if (fail || granted) begin
        expired = 0;
        break;
      end
    end
    ext_load = 1'b0;
  endtask

  typedef struct {
    bit          acq;
    bit          rel;
    logic [39:0] exp_out;
    logic [31:0] exp_slave;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int  wr, rd, fl, bw;
    bit  gs, ex;

    // Uncontended acquire/release cycle by cycle, including ignored and simultaneous requests.
    vecs[0]  = '{0, 0, mk(0,0,0,0,0,0,0,32'h0),        32'h0};
    vecs[1]  = '{1, 0, mk(0,1,0,0,1,1,0,C_LOCK_WORD),  32'h0};
    vecs[2]  = '{0, 0, mk(0,1,0,0,1,0,1,32'h0),        C_LOCK_WORD};
    vecs[3]  = '{0, 0, mk(1,0,0,0,0,0,0,32'h0),        C_LOCK_WORD};
    vecs[4]  = '{1, 0, mk(1,0,0,0,0,0,0,32'h0),        C_LOCK_WORD};
    vecs[5]  = '{0, 1, mk(0,1,0,1,1,1,0,C_REL_WORD),   C_LOCK_WORD};
    vecs[6]  = '{0, 0, mk(0,0,0,0,0,0,0,32'h0),        C_REL_WORD};
    vecs[7]  = '{0, 1, mk(0,0,0,0,0,0,0,32'h0),        C_REL_WORD};
    vecs[8]  = '{1, 1, mk(0,1,0,0,1,1,0,C_LOCK_WORD),  C_REL_WORD};
    vecs[9]  = '{0, 0, mk(0,1,0,0,1,0,1,32'h0),        C_LOCK_WORD};
    vecs[10] = '{0, 0, mk(1,0,0,0,0,0,0,32'h0),        C_LOCK_WORD};
    vecs[11] = '{0, 1, mk(0,1,0,1,1,1,0,C_REL_WORD),   C_LOCK_WORD};
    vecs[12] = '{0, 0, mk(0,0,0,0,0,0,0,32'h0),        C_REL_WORD};

    reset_n = 1'b0; req_acquire = 1'b0; req_release = 1'b0;
    ext_load = 1'b1; ext_val = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {24'h0, outs()}, 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    ext_load = 1'b0;
    check("idle_after_reset", {24'h0, outs()}, 64'h0);

    for (int i = 0; i < 13; i++) begin
      req_acquire = vecs[i].acq;
      req_release = vecs[i].rel;
      step();
      check($sformatf("vec%0d_outputs", i), {24'h0, outs()}, {24'h0, vecs[i].exp_out});
      check($sformatf("vec%0d_slave", i), {32'h0, slave_val}, {32'h0, vecs[i].exp_slave});
    end
    req_acquire = 1'b0;
    req_release = 1'b0;

    // Held by another owner for the whole attempt: retries run out.
    set_slave(C_OTHER);
    req_acquire = 1'b1;
    watch(2000, -1, wr, rd, fl, bw, gs, ex);
    check("exhaust_timeout", {63'h0, ex}, 64'h0);
    check("exhaust_writes", wr, C_MAX_RETRIES);
    check("exhaust_reads", rd, C_MAX_RETRIES);
    check("exhaust_wdata", bw, 0);
    check("exhaust_fail", fl, 1);
    check("exhaust_granted", {63'h0, gs}, 64'h0);
    check("exhaust_gap_count", gaps.size(), C_MAX_RETRIES - 1);
    for (int k = 0; k < gaps.size(); k++)
      check($sformatf("exhaust_gap%0d", k), gaps[k], exp_gap(k));
    step();
    check("fail_one_cycle", {60'h0, fail, busy, granted, done}, 64'h0);
    check("exhaust_slave", {32'h0, slave_val}, {32'h0, C_OTHER});

    // Other owner lets go after 10 cycles; the retry then wins.
    set_slave(C_OTHER);
    ext_val = 32'h0002_0000;
    req_acquire = 1'b1;
    watch(2000, 9, wr, rd, fl, bw, gs, ex);
    check("contend_timeout", {63'h0, ex}, 64'h0);
    check("contend_granted", {63'h0, gs}, 64'h1);
    check("contend_fail", fl, 0);
    check("contend_writes", wr, 3);
    check("contend_slave", {32'h0, slave_val}, {32'h0, C_LOCK_WORD});
    req_release = 1'b1;
    step();
    req_release = 1'b0;
    check("release_strobe", {24'h0, outs()}, {24'h0, mk(0,1,0,1,1,1,0,C_REL_WORD)});
    step();
    check("release_slave", {32'h0, slave_val}, {32'h0, C_REL_WORD});
    check("release_idle", {24'h0, outs()}, 64'h0);

    // Asynchronous reset while backing off.
    set_slave(C_OTHER);
    req_acquire = 1'b1;
    step();
    req_acquire = 1'b0;
    step();
    step();
    check("backoff_busy", {63'h0, busy}, 64'h1);
    #2 reset_n = 1'b0;
    #1 check("async_reset_outputs", {24'h0, outs()}, 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    check("post_reset_idle", {24'h0, outs()}, 64'h0);
    set_slave(32'h0);
    req_acquire = 1'b1;
    step();
    req_acquire = 1'b0;
    check("post_reset_write", {24'h0, outs()}, {24'h0, mk(0,1,0,0,1,1,0,C_LOCK_WORD)});
    step();
    step();
    check("post_reset_granted", {63'h0, granted}, 64'h1);
    check("post_reset_slave", {32'h0, slave_val}, {32'h0, C_LOCK_WORD});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
